// File: rtl/sysclk_reset_gen_pkg.sv
// Shared encodings and helpers for the system clock divider and reset sequencer.
package sysclk_reset_gen_pkg;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'b00,
        CAUSE_PIN  = 2'b01,
        CAUSE_SOFT = 2'b10,
        CAUSE_WDT  = 2'b11
    } rst_cause_t;

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_HOLD   = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    // Ceiling log2, never narrower than one bit so counters always exist.
    function automatic int clog2_min1(input int value);
        int width;
        width = 0;
        for (longint v = 1; v < longint'(value); v = v * 2) begin
            width++;
        end
        return (width < 1) ? 1 : width;
    endfunction

endpackage

// File: rtl/sysclk_reset_gen_sync.sv
// Async-assert / sync-release synchroniser for the board reset pin.
module reset_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic b_reset,
    output logic rel
);

    if (SYNC_STAGES < 2) begin : g_stage_check
        $error("reset_sync: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    always_ff @(posedge clk_in or negedge b_reset) begin
        if (!b_reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rel = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/sysclk_reset_gen.sv
// Divides clk_in down to sys_clk and sequences the system reset from the pin,
// software requests and the watchdog, recording the cause of the last reset.
module sysclk_reset_gen
    import sysclk_reset_gen_pkg::*;
#(
    parameter int OSC_CLOCK   = 12000000,
    parameter int CPU_CLOCK   = 3000000,
    parameter int DIV         = (OSC_CLOCK / CPU_CLOCK) / 2,
    parameter int RES_DELAY   = 4,
    parameter int SYNC_STAGES = 2,
    parameter int WDT_TIMEOUT = 65536
) (
    input  logic       clk_in,
    input  logic       b_reset,
    input  logic       soft_rst,
    input  logic       wdt_kick,
    output logic       sys_clk,
    output logic       sys_clk_rise,
    output logic       sys_res,
    output logic [1:0] rst_cause
);

    if (DIV < 1) begin : g_div_check
        $error("sysclk_reset_gen: DIV must be at least 1");
    end
    if (RES_DELAY < 1 || RES_DELAY > 255) begin : g_delay_check
        $error("sysclk_reset_gen: RES_DELAY must be in 1..255");
    end

    localparam int DIV_W = clog2_min1(DIV);
    localparam int WDT_W = clog2_min1(WDT_TIMEOUT);
    localparam bit WDT_EN = (WDT_TIMEOUT != 0);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);
    localparam logic [7:0]       DELAY_LAST = 8'(RES_DELAY - 1);
    localparam logic [WDT_W-1:0] WDT_LAST   = WDT_EN ? WDT_W'(WDT_TIMEOUT - 1) : '0;

    logic             rel;
    logic             rise_edge;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             sys_clk_q, sys_clk_d;
    logic             sys_clk_rise_q, sys_clk_rise_d;
    logic             sys_res_q, sys_res_d;
    rst_cause_t       cause_q, cause_d;
    state_t           state_q, state_d;
    logic [7:0]       delay_cnt_q, delay_cnt_d;
    logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;

    reset_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_reset_sync (
        .clk_in (clk_in),
        .b_reset(b_reset),
        .rel    (rel)
    );

    // rise_edge marks the clk_in edge that will take sys_clk from 0 to 1.
    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        sys_clk_d = sys_clk_q;
        rise_edge = 1'b0;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            sys_clk_d = ~sys_clk_q;
            rise_edge = ~sys_clk_q;
        end
        sys_clk_rise_d = rise_edge;
    end

    always_comb begin
        state_d     = state_q;
        delay_cnt_d = delay_cnt_q;
        wdt_cnt_d   = wdt_cnt_q;
        cause_d     = cause_q;
        if (rise_edge) begin
            unique case (state_q)
                ST_ASSERT: begin
                    if (rel) begin
                        state_d     = ST_HOLD;
                        delay_cnt_d = '0;
                    end
                end
                ST_HOLD: begin
                    wdt_cnt_d = '0;
                    if (delay_cnt_q == DELAY_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        delay_cnt_d = delay_cnt_q + 8'd1;
                    end
                end
                ST_RUN: begin
                    wdt_cnt_d = wdt_cnt_q + 1'b1;
                    if (soft_rst) begin
                        state_d     = ST_HOLD;
                        cause_d     = CAUSE_SOFT;
                        wdt_cnt_d   = '0;
                        delay_cnt_d = '0;
                    end else if (wdt_kick) begin
                        wdt_cnt_d = '0;
                    end else if (WDT_EN && wdt_cnt_q == WDT_LAST) begin
                        state_d     = ST_HOLD;
                        cause_d     = CAUSE_WDT;
                        wdt_cnt_d   = '0;
                        delay_cnt_d = '0;
                    end
                end
                default: begin
                    state_d = ST_ASSERT;
                end
            endcase
        end
        // Registered from the next state so sys_res moves on the same rise edge.
        sys_res_d = (state_d != ST_RUN);
    end

    always_ff @(posedge clk_in or negedge b_reset) begin
        if (!b_reset) begin
            div_cnt_q      <= '0;
            sys_clk_q      <= 1'b0;
            sys_clk_rise_q <= 1'b0;
            sys_res_q      <= 1'b1;
            cause_q        <= CAUSE_PIN;
            state_q        <= ST_ASSERT;
            delay_cnt_q    <= '0;
            wdt_cnt_q      <= '0;
        end else begin
            div_cnt_q      <= div_cnt_d;
            sys_clk_q      <= sys_clk_d;
            sys_clk_rise_q <= sys_clk_rise_d;
            sys_res_q      <= sys_res_d;
            cause_q        <= cause_d;
            state_q        <= state_d;
            delay_cnt_q    <= delay_cnt_d;
            wdt_cnt_q      <= wdt_cnt_d;
        end
    end

    assign sys_clk      = sys_clk_q;
    assign sys_clk_rise = sys_clk_rise_q;
    assign sys_res      = sys_res_q;
    assign rst_cause    = cause_q;

endmodule
